// File: rtl/dram_burst_model.sv
// dram_burst_model: cycle-level burst DRAM model with byte enables, credit back-pressure and
// fixed read latency; define DRAM_BURST_MODEL_REFRESH_EN to add periodic refresh stalls.
module dram_burst_model #(
  parameter int DATA_WIDTH      = 144,
  parameter int DRAM_DEPTH      = 16384,
  parameter int BURST_LEN       = 2,
  parameter int READ_LATENCY    = 16,
  parameter int CMD_WAIT_THRESH = 64,
  parameter int CMD_OVER_THRESH = 72,
  parameter int HARD_READY      = 0,
  parameter int REFRESH_PERIOD  = 1024,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic                    dram_clk,
  input  logic                    dram_rst,
  input  logic [31:0]             dram_cmd_addr,
  input  logic                    dram_cmd_rnw,
  input  logic                    dram_cmd_valid,
  output logic                    dram_cmd_ack,
  input  logic [DATA_WIDTH-1:0]   dram_wr_data,
  input  logic [DATA_WIDTH/8-1:0] dram_wr_be,
  output logic [DATA_WIDTH-1:0]   dram_rd_data,
  output logic                    dram_rd_valid,
  output logic                    dram_ready
);
  localparam int BW     = DATA_WIDTH / 8;
  localparam int BEAT_W = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int WORDS  = DRAM_DEPTH * BURST_LEN;
  localparam int WORD_W = WORDS > 1 ? $clog2(WORDS) : 1;
`ifdef DRAM_BURST_MODEL_REFRESH_EN
  typedef enum logic [1:0] {IDLE, BURST, REFRESH} state_t;
`else
  typedef enum logic [1:0] {IDLE, BURST} state_t;
`endif
  state_t state;
  logic [BEAT_W-1:0] beat, cur_beat;
  logic [31:0] burst_q, cur_burst, cmd_acc;
  logic rnw_q, cur_rnw, accept, exec, rd_exec, credit_ok, refresh_hold;
  logic [WORD_W-1:0] word;
  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_pipe;

  if (DATA_WIDTH % 8 != 0 || BURST_LEN < 1 || READ_LATENCY < 2 || DRAM_DEPTH < 1 ||
      CMD_OVER_THRESH < CMD_WAIT_THRESH || REFRESH_PERIOD < 1 || REFRESH_CYCLES < 1) begin : g_bad_params
    $error("dram_burst_model: illegal parameter combination");
  end

`ifdef DRAM_BURST_MODEL_REFRESH_EN
  logic [31:0] ref_cnt, ref_len;
  logic refresh_pending;
  assign refresh_hold = refresh_pending;
  assign dram_ready = cmd_acc < CMD_WAIT_THRESH && state != REFRESH;
  // The period counter free-runs; a request raised mid-burst waits until the FSM is back in IDLE.
  always_ff @(posedge dram_clk)
    if (dram_rst) begin
      ref_cnt <= '0;
      ref_len <= '0;
      refresh_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_cnt == REFRESH_PERIOD - 1 ? 32'd0 : ref_cnt + 32'd1;
      ref_len <= state == REFRESH ? ref_len + 32'd1 : 32'd0;
      refresh_pending <= ref_cnt == REFRESH_PERIOD - 1 ||
                         (refresh_pending && !(state == REFRESH && ref_len == REFRESH_CYCLES - 1));
    end
`else
  assign refresh_hold = 1'b0;
  assign dram_ready = cmd_acc < CMD_WAIT_THRESH;
`endif

  assign credit_ok    = HARD_READY != 0 ? dram_ready : cmd_acc < CMD_OVER_THRESH;
  assign accept       = !dram_rst && dram_cmd_valid && state == IDLE && credit_ok && !refresh_hold;
  assign dram_cmd_ack = accept;
  assign cur_burst    = accept ? (dram_cmd_addr >> 2) % 32'(DRAM_DEPTH) : burst_q;
  assign cur_rnw      = accept ? dram_cmd_rnw : rnw_q;
  assign cur_beat     = accept ? '0 : beat;
  assign exec         = !dram_rst && (accept || state == BURST);
  assign rd_exec      = exec && cur_rnw;
  assign word         = WORD_W'(cur_burst * 32'(BURST_LEN) + 32'(cur_beat));

  always_ff @(posedge dram_clk)
    if (exec && !cur_rnw)
      for (int i = 0; i < BW; i++)
        if (dram_wr_be[i]) mem[word][i*8 +: 8] <= dram_wr_data[i*8 +: 8];

  always_ff @(posedge dram_clk)
    if (dram_rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LATENCY-2:0], rd_exec};
      rd_pipe[0] <= rd_exec ? mem[word] : '0;
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

  assign dram_rd_valid = vld_pipe[READ_LATENCY-1];
  assign dram_rd_data  = rd_pipe[READ_LATENCY-1];

  always_ff @(posedge dram_clk)
    if (dram_rst) begin
      state   <= IDLE;
      beat    <= '0;
      burst_q <= '0;
      rnw_q   <= 1'b0;
      cmd_acc <= '0;
    end else begin
      cmd_acc <= accept ? cmd_acc + 32'd1 : cmd_acc != 32'd0 ? cmd_acc - 32'd1 : cmd_acc;
      if (accept) begin
        burst_q <= cur_burst;
        rnw_q   <= dram_cmd_rnw;
      end
      case (state)
        IDLE:
`ifdef DRAM_BURST_MODEL_REFRESH_EN
          if (refresh_pending) state <= REFRESH;
          else
`endif
          if (accept && BURST_LEN > 1) begin
            state <= BURST;
            beat  <= BEAT_W'(1);
          end
        BURST: begin
          beat <= beat + 1'b1;
          if (beat == BEAT_W'(BURST_LEN - 1)) begin
            state <= IDLE;
            beat  <= '0;
          end
        end
`ifdef DRAM_BURST_MODEL_REFRESH_EN
        REFRESH: if (ref_len == REFRESH_CYCLES - 1) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule
